ext_chan_arbiter: RTL and testbench
===================================

# ext_chan_arbiter

Round-robin arbiter that shares one external-channel bus between `N_REQ` requesters, such as CPU cores or DMA engines. The bus is the `ext_chan_*` request/done/nodata handshake used by the memory-mapped peripherals (RS232 data port and others). The block latches one requester's transaction, drives it onto the channel, and waits for `r_dn`, `w_dn` or `nodata` from the peripheral. It then returns the result to that requester only, and rotates priority.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, `` `ADDR_SIZE ``: channel-number width.
- `DATA_W`, `` `DATA_SIZE ``: data width.
- `TIMEOUT`, 1024: WAIT-state cycle limit. Used only with `EXT_CHAN_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `rq_no`  in  N_REQ*ADDR_W  per-requester channel number; slice i belongs to requester i.
- `rq_data`  in  N_REQ*DATA_W  per-requester write data.
- `rq_r_q`, `rq_w_q`  in  N_REQ  per-requester read/write request levels.
- `rq_r_dn`, `rq_w_dn`, `rq_nodata`  out  N_REQ  one-cycle response pulses to the granted requester.
- `rq_data_out`  out  DATA_W  read data. Valid only with `rq_r_dn`, 0 otherwise.
- `ch_no_out`  out  ADDR_W  channel number driven to the peripherals.
- `ch_data_out`  out  DATA_W  write data to the peripherals.
- `ch_r_q`, `ch_w_q`  out  1  channel request levels.
- `ch_no_in`  in  ADDR_W  responding peripheral's channel number.
- `ch_data_in`  in  DATA_W  read data from the peripheral.
- `ch_r_dn`, `ch_w_dn`, `ch_nodata`  in  1  peripheral responses.
- `grant_id`  out  $clog2(N_REQ)  current or last grant.
- `busy`  out  1  high in every state except IDLE.
- `timeout_p`  out  1  one-cycle timeout pulse. Only present with `EXT_CHAN_TIMEOUT_EN`.

## Operation
- **States:** IDLE, WAIT, RESP, RELEASE.
- **IDLE:**
  - A requester is pending when `rq_r_q[i]|rq_w_q[i]` is high.
  - Search for a pending requester starting at `last_grant+1` and wrapping modulo `N_REQ`.
  - On a hit, latch `no`, `data`, `dir` and `id`. If both `rq_r_q` and `rq_w_q` are high, the write wins.
  - Assert `ch_r_q` or `ch_w_q` from the next cycle; go to WAIT.
- **WAIT:**
  - Hold `ch_*_q`, `ch_no_out` and `ch_data_out` stable.
  - A response counts only if it is `ch_r_dn`, `ch_w_dn` or `ch_nodata` with `ch_no_in == latched no`. `ch_nodata` is accepted without the `ch_no_in` check, because peripherals do not drive `no` with `nodata`.
  - On a valid response: drop `ch_*_q` and capture `ch_data_in` for reads; go to RESP.
  - A `dn` whose type does not match `dir` is ignored.
- **RESP:**
  - Pulse exactly one of `rq_r_dn[id]`, `rq_w_dn[id]` or `rq_nodata[id]` for one cycle. Drive `rq_data_out` with the read data for a read.
  - Set `last_grant = id`; go to RELEASE.
- **RELEASE:**
  - Stay until `ch_r_dn`, `ch_w_dn` and `ch_nodata` are all low. Minimum 1 cycle.
  - Then go to IDLE.
  - This guarantees the granted requester has dropped its `q` before re-arbitration. Requesters must deassert `q` within 1 cycle of their `dn`.
- **Reset values:**
  - All outputs 0.
  - `last_grant = N_REQ-1`, so requester 0 has first priority.
  - State IDLE.
  - Reset in any state aborts the transaction immediately: no response pulse is issued and `ch_*_q` are low on the next cycle.
- **Non-granted requesters:** their `q` is held and never answered until they win.

## Timing
- Request first seen high at cycle 0 in IDLE: `ch_*_q` high at cycle 1.
- Peripheral response at cycle k: `ch_*_q` low at k+1; `rq_*` pulse at k+1.
- Minimum turnaround between grants is 4 cycles.
- Fairness: each pending requester is granted within `N_REQ` transactions.
- Outputs to the channel are registered. There is no combinational path from `rq_*` to `ch_*`.

## Configuration
- **`EXT_CHAN_TIMEOUT_EN` defined:**
  - A WAIT-cycle counter, width $clog2(TIMEOUT+1), clears on entering WAIT.
  - When it reaches `TIMEOUT` with no response, drop `ch_*_q`, pulse `rq_nodata[id]` and `timeout_p` together, and go to RELEASE.
  - A response arriving in the same cycle as expiry wins over the timeout.
- **Undefined:** there is no counter and no `timeout_p` port; WAIT is unbounded.

## Structure
- State encodings (`EXT_ARB_IDLE`..`EXT_ARB_RELEASE`) and the default `TIMEOUT` go in `defines.v`. Widths come from `sizes.v`.
- One sub-module, `rr_pick`: combinational round-robin priority encoder with inputs pending mask and `last_grant`, outputs `hit` and `id`.

## Test plan
- **Single write:** `rq_w_q[2]=1`, `no=RS232_DATA_ADDR`, `data=0x41`. Expect `ch_w_q=1` at cycle 1 with `ch_data_out=0x41`. Peripheral `w_dn` at cycle 5 gives `rq_w_dn[2]` pulse at cycle 6, and no other requester is pulsed.
- **Round-robin:** all 4 requesters read continuously. Grant order is 0,1,2,3,0, and `rq_data_out` matches each `ch_data_in` value (0x10, 0x11, 0x12, 0x13, 0x14).
- **Nodata:** peripheral answers `ch_nodata` for a read from requester 1. Expect `rq_nodata[1]` pulse, `rq_r_dn` never asserted, and `rq_data_out=0`.
- **Wrong channel:** `ch_r_dn` arrives with `ch_no_in != no`. It is ignored and the block stays in WAIT. A matching `dn` later completes the transaction normally.
- **Reset mid-WAIT:** `rst` asserted during WAIT. Next cycle all outputs are 0 and the state is IDLE; after reset, requester 0 is granted first.
- **Timeout** (`EXT_CHAN_TIMEOUT_EN`, `TIMEOUT=8`): no response. At WAIT cycle 8, `rq_nodata[id]` and `timeout_p` pulse together and `ch_*_q` drops.

Source files
------------

// File: rtl/ext_chan_arbiter_pkg.sv
// ext_chan_arbiter_pkg: arbiter state encodings, default channel/data widths and default WAIT timeout
package ext_chan_arbiter_pkg;
   localparam int ADDR_SIZE = 8;
   localparam int DATA_SIZE = 8;
   localparam int EXT_ARB_TIMEOUT = 1024;
   localparam logic [ADDR_SIZE-1:0] RS232_DATA_ADDR = 8'h04;
   typedef enum logic [1:0] {EXT_ARB_IDLE, EXT_ARB_WAIT, EXT_ARB_RESP, EXT_ARB_RELEASE} arb_state_t;
endpackage

// File: rtl/ext_chan_arbiter_pick.sv
// rr_pick: combinational round-robin encoder, first pending requester after last_grant (wrapping)
module rr_pick
   import ext_chan_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IW = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] pend,
   input  logic [IW-1:0]    last_grant,
   output logic             hit,
   output logic [IW-1:0]    id
);
   logic [IW-1:0] j;
   assign hit = |pend;
   always_comb begin
      id = '0;
      j = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         j = IW'((int'(last_grant) + i) % N_REQ);
         if (pend[j]) id = j;
      end
   end
endmodule

// File: rtl/ext_chan_arbiter.sv
// ext_chan_arbiter: round-robin sharing of one ext_chan bus; EXT_CHAN_TIMEOUT_EN adds a bounded WAIT with timeout_p
module ext_chan_arbiter
   import ext_chan_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ADDR_W = ADDR_SIZE,
   parameter int DATA_W = DATA_SIZE,
   parameter int TIMEOUT = EXT_ARB_TIMEOUT,
   parameter int IW = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ*ADDR_W-1:0] rq_no,
   input  logic [N_REQ*DATA_W-1:0] rq_data,
   input  logic [N_REQ-1:0]        rq_r_q,
   input  logic [N_REQ-1:0]        rq_w_q,
   output logic [N_REQ-1:0]        rq_r_dn,
   output logic [N_REQ-1:0]        rq_w_dn,
   output logic [N_REQ-1:0]        rq_nodata,
   output logic [DATA_W-1:0]       rq_data_out,
   output logic [ADDR_W-1:0]       ch_no_out,
   output logic [DATA_W-1:0]       ch_data_out,
   output logic                    ch_r_q,
   output logic                    ch_w_q,
   input  logic [ADDR_W-1:0]       ch_no_in,
   input  logic [DATA_W-1:0]       ch_data_in,
   input  logic                    ch_r_dn,
   input  logic                    ch_w_dn,
   input  logic                    ch_nodata,
   output logic [IW-1:0]           grant_id,
`ifdef EXT_CHAN_TIMEOUT_EN
   output logic                    timeout_p,
`endif
   output logic                    busy
);
   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
      $error("ext_chan_arbiter: unsupported parameters");
   end
   arb_state_t st;
   logic [IW-1:0] last_grant, pick;
   logic hit, dir, rd_ok, wr_ok;
   rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .pend(rq_r_q | rq_w_q),
      .last_grant(last_grant),
      .hit(hit),
      .id(pick)
   );
   // nodata carries no channel number, so only dn pulses are address-checked
   assign rd_ok = ch_r_dn & ~dir & (ch_no_in == ch_no_out);
   assign wr_ok = ch_w_dn & dir & (ch_no_in == ch_no_out);
   assign busy = st != EXT_ARB_IDLE;
`ifdef EXT_CHAN_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= EXT_ARB_IDLE;
         last_grant <= IW'(N_REQ - 1);
         grant_id <= '0;
         dir <= 1'b0;
         ch_r_q <= 1'b0;
         ch_w_q <= 1'b0;
         ch_no_out <= '0;
         ch_data_out <= '0;
         rq_r_dn <= '0;
         rq_w_dn <= '0;
         rq_nodata <= '0;
         rq_data_out <= '0;
`ifdef EXT_CHAN_TIMEOUT_EN
         cnt <= '0;
         timeout_p <= 1'b0;
`endif
      end else begin
         rq_r_dn <= '0;
         rq_w_dn <= '0;
         rq_nodata <= '0;
         rq_data_out <= '0;
`ifdef EXT_CHAN_TIMEOUT_EN
         timeout_p <= 1'b0;
`endif
         case (st)
            EXT_ARB_IDLE:
               if (hit) begin
                  grant_id <= pick;
                  dir <= rq_w_q[pick];
                  ch_w_q <= rq_w_q[pick];
                  ch_r_q <= ~rq_w_q[pick];
                  ch_no_out <= rq_no[pick*ADDR_W +: ADDR_W];
                  ch_data_out <= rq_data[pick*DATA_W +: DATA_W];
`ifdef EXT_CHAN_TIMEOUT_EN
                  cnt <= '0;
`endif
                  st <= EXT_ARB_WAIT;
               end
            EXT_ARB_WAIT:
               if (rd_ok | wr_ok | ch_nodata) begin
                  ch_r_q <= 1'b0;
                  ch_w_q <= 1'b0;
                  rq_r_dn[grant_id] <= rd_ok;
                  rq_w_dn[grant_id] <= wr_ok;
                  rq_nodata[grant_id] <= ~rd_ok & ~wr_ok;
                  rq_data_out <= rd_ok ? ch_data_in : '0;
                  st <= EXT_ARB_RESP;
               end
`ifdef EXT_CHAN_TIMEOUT_EN
               else if (cnt == CW'(TIMEOUT - 1)) begin
                  ch_r_q <= 1'b0;
                  ch_w_q <= 1'b0;
                  rq_nodata[grant_id] <= 1'b1;
                  timeout_p <= 1'b1;
                  last_grant <= grant_id;
                  st <= EXT_ARB_RELEASE;
               end else
                  cnt <= cnt + 1'b1;
`endif
            EXT_ARB_RESP: begin
               last_grant <= grant_id;
               st <= EXT_ARB_RELEASE;
            end
            EXT_ARB_RELEASE:
               if (!(ch_r_dn | ch_w_dn | ch_nodata)) st <= EXT_ARB_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ext_chan_arbiter.sv
// tb_ext_chan_arbiter: directed vectors with hand-computed expectations for ext_chan_arbiter
module tb_ext_chan_arbiter;
   import ext_chan_arbiter_pkg::*;
   localparam int N = 4, AW = ADDR_SIZE, DW = DATA_SIZE, IW = 2;
   logic clk = 1'b0, rst = 1'b1;
   logic [N*AW-1:0] rq_no = '0;
   logic [N*DW-1:0] rq_data = '0;
   logic [N-1:0] rq_r_q = '0, rq_w_q = '0;
   logic [N-1:0] rq_r_dn, rq_w_dn, rq_nodata;
   logic [DW-1:0] rq_data_out, ch_data_out;
   logic [DW-1:0] ch_data_in = '0;
   logic [AW-1:0] ch_no_out;
   logic [AW-1:0] ch_no_in = '0;
   logic ch_r_q, ch_w_q, busy;
   logic ch_r_dn = 1'b0, ch_w_dn = 1'b0, ch_nodata = 1'b0;
   logic [IW-1:0] grant_id;
`ifdef EXT_CHAN_TIMEOUT_EN
   logic timeout_p;
`endif
   int n_vec = 0, n_bad = 0;
   always #5 clk = ~clk;
   ext_chan_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
      .clk(clk),
      .rst(rst),
      .rq_no(rq_no),
      .rq_data(rq_data),
      .rq_r_q(rq_r_q),
      .rq_w_q(rq_w_q),
      .rq_r_dn(rq_r_dn),
      .rq_w_dn(rq_w_dn),
      .rq_nodata(rq_nodata),
      .rq_data_out(rq_data_out),
      .ch_no_out(ch_no_out),
      .ch_data_out(ch_data_out),
      .ch_r_q(ch_r_q),
      .ch_w_q(ch_w_q),
      .ch_no_in(ch_no_in),
      .ch_data_in(ch_data_in),
      .ch_r_dn(ch_r_dn),
      .ch_w_dn(ch_w_dn),
      .ch_nodata(ch_nodata),
      .grant_id(grant_id),
`ifdef EXT_CHAN_TIMEOUT_EN
      .timeout_p(timeout_p),
`endif
      .busy(busy)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic wait_q(input string tag);
      int k = 0;
      while (!(ch_r_q | ch_w_q) && k < 20) begin
         tick();
         k++;
      end
      chk(tag, 32'(ch_r_q | ch_w_q), 1);
   endtask
   task automatic idle_all();
      rq_r_q = '0;
      rq_w_q = '0;
      ch_r_dn = 1'b0;
      ch_w_dn = 1'b0;
      ch_nodata = 1'b0;
      repeat (3) tick();
   endtask
   initial begin
      repeat (2) tick();
      chk("rst_ch_q", {ch_r_q, ch_w_q}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pulses", {rq_r_dn, rq_w_dn, rq_nodata}, 0);
      chk("rst_bus", {ch_no_out, ch_data_out, rq_data_out, grant_id}, 0);
      rst = 1'b0;
      rq_no[2*AW +: AW] = RS232_DATA_ADDR;
      rq_data[2*DW +: DW] = 8'h41;
      rq_w_q[2] = 1'b1;
      tick();
      chk("wr_ch_w_q", ch_w_q, 1);
      chk("wr_ch_r_q", ch_r_q, 0);
      chk("wr_data", ch_data_out, 8'h41);
      chk("wr_no", ch_no_out, RS232_DATA_ADDR);
      chk("wr_grant", grant_id, 2);
      repeat (4) tick();
      chk("wr_hold", {ch_w_q, ch_data_out}, {1'b1, 8'h41});
      ch_w_dn = 1'b1;
      ch_no_in = RS232_DATA_ADDR;
      tick();
      chk("wr_dn", rq_w_dn, 4'b0100);
      chk("wr_others", {rq_r_dn, rq_nodata}, 0);
      chk("wr_drop", ch_w_q, 0);
      ch_w_dn = 1'b0;
      rq_w_q = '0;
      tick();
      chk("wr_pulse_len", rq_w_dn, 0);
      chk("wr_release", busy, 1);
      tick();
      chk("wr_idle", busy, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) rq_no[i*AW +: AW] = AW'(8'h20 + i);
      rq_r_q = 4'hf;
      for (int t = 0; t < 5; t++) begin
         wait_q("rr_wait");
         chk("rr_grant", grant_id, t % N);
         chk("rr_dir", ch_r_q, 1);
         ch_r_dn = 1'b1;
         ch_no_in = AW'(8'h20 + t % N);
         ch_data_in = DW'(8'h10 + t);
         tick();
         chk("rr_dn", rq_r_dn, 1 << (t % N));
         chk("rr_data", rq_data_out, 8'h10 + t);
         ch_r_dn = 1'b0;
         if (t == 4) rq_r_q = '0;
         tick();
         chk("rr_data_zero", rq_data_out, 0);
      end
      idle_all();
      rq_r_q = 4'b0010;
      wait_q("nd_wait");
      chk("nd_grant", grant_id, 1);
      ch_nodata = 1'b1;
      ch_no_in = 8'h55;
      ch_data_in = 8'haa;
      tick();
      chk("nd_pulse", rq_nodata, 4'b0010);
      chk("nd_no_rdn", rq_r_dn, 0);
      chk("nd_data", rq_data_out, 0);
      chk("nd_drop", ch_r_q, 0);
      rq_r_q = '0;
      repeat (2) begin
         tick();
         chk("nd_release_hold", busy, 1);
      end
      ch_nodata = 1'b0;
      tick();
      chk("nd_idle", busy, 0);
      rq_w_q[2] = 1'b1;
      wait_q("rm_wait");
      chk("rm_grant", grant_id, 2);
      rq_r_q = 4'b1001;
      rst = 1'b1;
      tick();
      chk("rm_ch_q", {ch_r_q, ch_w_q}, 0);
      chk("rm_busy", busy, 0);
      chk("rm_bus", {ch_no_out, ch_data_out, rq_data_out, grant_id}, 0);
      chk("rm_pulses", {rq_r_dn, rq_w_dn, rq_nodata}, 0);
      rst = 1'b0;
      tick();
      chk("rm_first_grant", grant_id, 0);
      chk("rm_first_dir", {ch_r_q, ch_w_q}, 2'b10);
      ch_r_dn = 1'b1;
      ch_no_in = 8'h20;
      ch_data_in = 8'h5a;
      tick();
      chk("rm_dn", rq_r_dn, 4'b0001);
      idle_all();
      rq_no[3*AW +: AW] = 8'h33;
      rq_r_q = 4'b1000;
      wait_q("wc_wait");
      chk("wc_grant", grant_id, 3);
      ch_r_dn = 1'b1;
      ch_no_in = 8'h34;
      ch_data_in = 8'h99;
      tick();
      chk("wc_no_ignored", {rq_r_dn, rq_nodata, ch_r_q}, 1);
      ch_r_dn = 1'b0;
      ch_w_dn = 1'b1;
      ch_no_in = 8'h33;
      tick();
      chk("wc_type_ignored", {rq_w_dn, rq_r_dn, ch_r_q}, 1);
      ch_w_dn = 1'b0;
      ch_r_dn = 1'b1;
      ch_data_in = 8'h77;
      tick();
      chk("wc_dn", rq_r_dn, 4'b1000);
      chk("wc_data", rq_data_out, 8'h77);
      idle_all();
`ifdef EXT_CHAN_TIMEOUT_EN
      rq_w_q = 4'b0010;
      wait_q("to_wait");
      chk("to_grant", grant_id, 1);
      repeat (7) tick();
      chk("to_before", {ch_w_q, timeout_p, rq_nodata}, 6'b100000);
      tick();
      chk("to_pulse", {ch_w_q, timeout_p, rq_nodata}, 6'b010010);
      rq_w_q = '0;
      tick();
      chk("to_pulse_len", {timeout_p, rq_nodata}, 0);
      idle_all();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
